// File: rtl/rr_encoder_4_2.sv
// Registered round-robin 4-to-2 encoder/arbiter with a valid/ack grant handshake.
// A grant is sticky until acked; acking re-arbitrates in the same cycle for bubble-free hand-off.
module rr_encoder_4_2 (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [3:0]   req,
  input  logic         ack,
  output logic [1:0]   code,
  output logic         valid,
  output logic [3:0]   grant
);

  localparam int unsigned N = 4;
  localparam int unsigned W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   ptr;
  logic [W-1:0]   ptr_nxt;
  logic [W-1:0]   code_nxt;
  logic           valid_nxt;
  logic [N-1:0]   grant_nxt;
  logic [W-1:0]   base_c;
  logic           hit_c;
  logic [W-1:0]   win_c;

  // First set request at or after base, wrapping mod N.
  function automatic logic [W:0] pick(input logic [N-1:0] r, input logic [W-1:0] base);
    logic           found;
    logic [W-1:0]   w;
    logic [W-1:0]   idx;
    found = 1'b0;
    w     = '0;
    for (int k = 0; k < int'(N); k++) begin
      idx = base + W'(k);
      if (r[idx] && !found) begin
        found = 1'b1;
        w     = idx;
      end
    end
    return {found, w};
  endfunction

  // Search base: an accepted grant searches from code+1, otherwise from ptr.
  always_comb begin
    base_c         = ptr;
    if (state == GRANT && ack) begin
      base_c = code + W'(1);
    end
    {hit_c, win_c} = pick(req, base_c);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    code_nxt  = code;
    valid_nxt = valid;
    grant_nxt = grant;
    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        grant_nxt = '0;
        if (en && hit_c) begin
          code_nxt  = win_c;
          valid_nxt = 1'b1;
          grant_nxt = N'(1) << win_c;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (ack) begin
          ptr_nxt = code + W'(1);
          if (en && hit_c) begin
            code_nxt  = win_c;
            valid_nxt = 1'b1;
            grant_nxt = N'(1) << win_c;
          end else begin
            valid_nxt = 1'b0;
            grant_nxt = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
        grant_nxt = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      code  <= '0;
      valid <= 1'b0;
      grant <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      code  <= code_nxt;
      valid <= valid_nxt;
      grant <= grant_nxt;
    end
  end

endmodule
